// File: rtl/uart_tx_rr_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources,
// with locked multi-byte messages and a one-byte-at-a-time TX handshake.
module uart_tx_rr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int TX_HOLDOFF   = 2,
    parameter int LOCK_TIMEOUT = 64,
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*8-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 tx_do_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_done_i,
    output logic [ID_W-1:0]      grant_id_o,
    output logic                 lock_active_o,
    output logic                 busy_o,
    output logic [15:0]          bytes_sent_o
);

    localparam int HOLD_W = (TX_HOLDOFF > 1) ? $clog2(TX_HOLDOFF) : 1;
    localparam int CNT_W  = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(TX_HOLDOFF - 1);
    localparam logic [CNT_W-1:0]  LOCK_LIMIT = CNT_W'(LOCK_TIMEOUT);
    localparam logic [ID_W-1:0]   PTR_RESET  = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLDOFF,
        S_WAIT_DONE
    } state_t;

    state_t              state_q;
    logic [ID_W-1:0]     ptr_q;
    logic [ID_W-1:0]     grant_q;
    logic                lock_q;
    logic [CNT_W-1:0]    lcnt_q;
    logic [HOLD_W-1:0]   hcnt_q;
    logic                tx_do_q;
    logic [7:0]          tx_data_q;
    logic                busy_q;
    logic [15:0]         bytes_q;

    logic [NUM_REQ-1:0]  eligible_d;
    logic [ID_W-1:0]     winner_d;
    logic                found_d;
    logic                accept_d;
    logic [7:0]          sel_data_d;
    logic                sel_last_d;

    // While a message is locked only its owner may be picked.
    always_comb begin
        eligible_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible_d[i] = req_valid_i[i] && (!lock_q || (grant_q == ID_W'(i)));
        end
    end

    always_comb begin
        logic [ID_W-1:0] cand;
        winner_d = ptr_q;
        found_d  = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found_d && eligible_d[cand]) begin
                found_d  = 1'b1;
                winner_d = cand;
            end
        end
    end

    assign sel_data_d = req_data_i[8*winner_d +: 8];
    assign sel_last_d = req_last_i[winner_d];
    assign accept_d   = !rst_i && (state_q == S_IDLE) && tx_done_i && found_d;

    always_comb begin
        req_ready_o = '0;
        if (accept_d) begin
            req_ready_o[winner_d] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ptr_q     <= PTR_RESET;
            grant_q   <= '0;
            lock_q    <= 1'b0;
            lcnt_q    <= '0;
            hcnt_q    <= '0;
            tx_do_q   <= 1'b0;
            tx_data_q <= '0;
            busy_q    <= 1'b0;
            bytes_q   <= '0;
        end else begin
            tx_do_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        state_q   <= S_ISSUE;
                        tx_do_q   <= 1'b1;
                        tx_data_q <= sel_data_d;
                        busy_q    <= 1'b1;
                        ptr_q     <= winner_d;
                        grant_q   <= winner_d;
                        lock_q    <= !sel_last_d;
                        lcnt_q    <= '0;
                    end else if (lock_q && !req_valid_i[grant_q]) begin
                        // A stalled owner loses the lock once the idle count reaches the limit.
                        if (LOCK_TIMEOUT != 0) begin
                            if (lcnt_q == LOCK_LIMIT) begin
                                lock_q <= 1'b0;
                                lcnt_q <= '0;
                            end else begin
                                lcnt_q <= lcnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    bytes_q <= bytes_q + 16'd1;
                    hcnt_q  <= '0;
                    state_q <= S_HOLDOFF;
                end
                S_HOLDOFF: begin
                    if (hcnt_q == HOLD_LAST) begin
                        state_q <= S_WAIT_DONE;
                    end else begin
                        hcnt_q <= hcnt_q + HOLD_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (tx_done_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_do_o       = tx_do_q;
    assign tx_data_o     = tx_data_q;
    assign grant_id_o    = grant_q;
    assign lock_active_o = lock_q;
    assign busy_o        = busy_q;
    assign bytes_sent_o  = bytes_q;

endmodule

// File: tb/tb_uart_tx_rr_arbiter.sv
// Bench for uart_tx_rr_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the arbitration rules.
module tb_uart_tx_rr_arbiter;

    localparam int N   = 4;
    localparam int HO  = 2;
    localparam int LTO = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_do;
    logic [7:0]     tx_data;
    logic           tx_done;
    logic [1:0]     grant_id;
    logic           lock_active;
    logic           busy;
    logic [15:0]    bytes_sent;

    uart_tx_rr_arbiter #(.NUM_REQ(N), .TX_HOLDOFF(HO), .LOCK_TIMEOUT(LTO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready),
        .tx_do_o(tx_do), .tx_data_o(tx_data), .tx_done_i(tx_done),
        .grant_id_o(grant_id), .lock_active_o(lock_active), .busy_o(busy),
        .bytes_sent_o(bytes_sent)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_since: 0 = free to accept, 1 = tx_do cycle, 2..HO+1 = holdoff, beyond = waiting for tx_done
    int          m_ptr, m_owner, m_cnt, m_since;
    bit          m_locked;
    logic [15:0] m_bytes;
    logic [7:0]  m_data;

    function automatic int pick(input logic [N-1:0] el, input int ptr);
        for (int k = 1; k <= N; k++) begin
            if (el[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] eligible();
        logic [N-1:0] m;
        m = req_valid;
        if (m_locked) begin
            for (int i = 0; i < N; i++) if (i != m_owner) m[i] = 1'b0;
        end
        return m;
    endfunction

    always @(posedge clk or posedge rst) begin
        int w;
        if (rst) begin
            m_ptr = N - 1; m_owner = 0; m_cnt = 0; m_since = 0;
            m_locked = 0; m_bytes = '0; m_data = '0;
        end else begin
            w = pick(eligible(), m_ptr);
            if (m_since == 0) begin
                if (tx_done && w >= 0) begin
                    m_data   = req_data[8*w +: 8];
                    m_ptr    = w;
                    m_owner  = w;
                    m_locked = !req_last[w];
                    m_cnt    = 0;
                    m_since  = 1;
                end else if (m_locked && !req_valid[m_owner]) begin
                    if (LTO != 0 && m_cnt == LTO) begin
                        m_locked = 0;
                        m_cnt    = 0;
                    end else begin
                        m_cnt++;
                    end
                end
            end else if (m_since <= HO + 1) begin
                if (m_since == 1) m_bytes = m_bytes + 16'd1;
                m_since++;
            end else if (tx_done) begin
                m_since = 0;
            end
        end
    end

    // ---------------- compare + monitor ----------------
    logic [N-1:0] acc_neg = '0;
    logic         td_neg  = 1'b0;
    int           cyc = 0, ready_cnt = 0, tx_cnt = 0;
    logic [7:0]   mon_bytes[$];
    int           mon_ids[$];
    int           mon_cyc[$];

    always @(negedge clk) begin
        int w;
        logic [N-1:0] exp_ready;
        if (rst) begin
            chk("rst_ready", 32'(req_ready), 0);
            chk("rst_tx_do", 32'(tx_do), 0);
            chk("rst_tx_data", 32'(tx_data), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_grant", 32'(grant_id), 0);
            chk("rst_lock", 32'(lock_active), 0);
            chk("rst_bytes", 32'(bytes_sent), 0);
        end else begin
            w = pick(eligible(), m_ptr);
            exp_ready = '0;
            if (m_since == 0 && tx_done && w >= 0) exp_ready[w] = 1'b1;
            chk("ready", 32'(req_ready), 32'(exp_ready));
            chk("tx_do", 32'(tx_do), 32'(m_since == 1));
            chk("tx_data", 32'(tx_data), 32'(m_data));
            chk("busy", 32'(busy), 32'(m_since != 0));
            chk("grant_id", 32'(grant_id), 32'(m_owner));
            chk("lock_active", 32'(lock_active), 32'(m_locked));
            chk("bytes_sent", 32'(bytes_sent), 32'(m_bytes));
        end
        cyc++;
        acc_neg = req_ready & req_valid;
        td_neg  = tx_do;
        if (|req_ready) ready_cnt++;
        if (tx_do) begin
            tx_cnt++;
            mon_bytes.push_back(tx_data);
            mon_ids.push_back(int'(grant_id));
            mon_cyc.push_back(cyc);
        end
    end

    // ---------------- stimulus ----------------
    logic [8:0] srcmem[N][64];
    int         head[N], tail[N];
    bit         rand_mode = 0, auto_done = 0, rand_done = 0, man_done = 1;
    int         done_delay = 0, busy_left = 0;

    task automatic push(input int i, input logic [7:0] d, input logic last);
        srcmem[i][tail[i] % 64] = {last, d};
        tail[i]++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (head[i] != tail[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = srcmem[i][head[i] % 64][7:0];
                req_last[i]        = srcmem[i][head[i] % 64][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i]        = 1'($urandom);
            end
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 0;
        return 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc_neg[i]) head[i]++;
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (head[i] == tail[i] && $urandom_range(0, 3) == 0)
                    push(i, 8'($urandom), ($urandom_range(0, 2) != 0));
            end
        end
        if (auto_done) begin
            if (td_neg) busy_left = rand_done ? int'($urandom_range(0, 5)) : done_delay;
            tx_done = (busy_left == 0);
            if (busy_left > 0) busy_left--;
        end else begin
            tx_done = man_done;
        end
        drive();
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (!(all_empty() && !busy)) begin
            step();
            n++;
            if (n > limit) begin
                total++; bad++;
                $display("FAIL wait_idle: still busy after %0d cycles", limit);
                return;
            end
        end
    endtask

    task automatic wait_tx(input int count, input int limit);
        int n;
        n = 0;
        while (mon_ids.size() < count) begin
            step();
            n++;
            if (n > limit) begin
                total++; bad++;
                $display("FAIL wait_tx: saw %0d bytes, needed %0d", mon_ids.size(), count);
                return;
            end
        end
    endtask

    task automatic clear_mon();
        mon_bytes.delete(); mon_ids.delete(); mon_cyc.delete();
    endtask

    task automatic chk_tx(input string tag, input int idx, input int id, input int b);
        if (idx < mon_ids.size()) begin
            chk($sformatf("%s_id%0d", tag, idx), 32'(mon_ids[idx]), 32'(id));
            chk($sformatf("%s_byte%0d", tag, idx), 32'(mon_bytes[idx]), 32'(b));
        end else begin
            chk($sformatf("%s_count", tag), 32'(mon_ids.size()), 32'(idx + 1));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    initial begin
        int r0, t0;
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_done = 1'b1;
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
        repeat (3) step();
        rst = 1'b0;

        // 1) single byte from requester 0
        push(0, 8'h41, 1'b1); drive();
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'h1);
        step();
        @(negedge clk);
        chk("t1_tx_do", 32'(tx_do), 1);
        chk("t1_tx_data", 32'(tx_data), 32'h41);
        step();
        @(negedge clk);
        chk("t1_bytes", 32'(bytes_sent), 1);
        chk("t1_tx_do_low", 32'(tx_do), 0);
        wait_idle(50);

        // 2) all four valid, rotation from a fresh pointer
        do_reset();
        clear_mon();
        auto_done = 1; done_delay = 3;
        push(0, 8'h10, 1); push(0, 8'h14, 1);
        push(1, 8'h11, 1); push(2, 8'h12, 1); push(3, 8'h13, 1);
        drive();
        wait_idle(200);
        chk_tx("t2", 0, 0, 8'h10); chk_tx("t2", 1, 1, 8'h11); chk_tx("t2", 2, 2, 8'h12);
        chk_tx("t2", 3, 3, 8'h13); chk_tx("t2", 4, 0, 8'h14);
        // tx_done low for 3 cycles after tx_do dominates the 2-cycle holdoff: 3 + 3 = 6
        for (int i = 1; i < mon_cyc.size(); i++)
            chk($sformatf("t2_gap%0d", i), 32'(mon_cyc[i] - mon_cyc[i-1]), 6);

        // 3) locked two-byte message from requester 1 among competitors
        clear_mon();
        push(1, 8'h48, 0); push(1, 8'h49, 1); push(0, 8'hA0, 1); push(2, 8'hC2, 1);
        drive();
        wait_idle(200);
        chk_tx("t3", 0, 1, 8'h48); chk_tx("t3", 1, 1, 8'h49);
        chk_tx("t3", 2, 2, 8'hC2); chk_tx("t3", 3, 0, 8'hA0);

        // 4) owner stalls mid-message; lock times out and requester 2 follows
        clear_mon();
        done_delay = 0;
        push(1, 8'h55, 0); push(2, 8'h66, 1);
        drive();
        wait_idle(300);
        chk_tx("t4", 0, 1, 8'h55); chk_tx("t4", 1, 2, 8'h66);
        // ISSUE + holdoff + one WAIT_DONE + (LTO+1) locked idle cycles + accept
        if (mon_cyc.size() >= 2) chk("t4_gap", 32'(mon_cyc[1] - mon_cyc[0]), 32'(HO + LTO + 4));
        chk("t4_unlocked", 32'(lock_active), 0);

        // 5) tx_done held low for 100 cycles blocks everything
        clear_mon();
        auto_done = 0; man_done = 1;
        push(3, 8'h31, 1); push(3, 8'h32, 1);
        drive();
        wait_tx(1, 20);
        man_done = 0; tx_done = 1'b0;
        push(0, 8'h30, 1); drive();
        r0 = ready_cnt; t0 = tx_cnt;
        repeat (100) step();
        chk("t5_no_ready", 32'(ready_cnt - r0), 0);
        chk("t5_no_tx_do", 32'(tx_cnt - t0), 0);
        man_done = 1; tx_done = 1'b1;
        wait_tx(2, 10);
        wait_idle(50);
        chk_tx("t5", 0, 3, 8'h31); chk_tx("t5", 1, 0, 8'h30); chk_tx("t5", 2, 3, 8'h32);

        // 6) reset while in holdoff with a lock held
        clear_mon();
        auto_done = 1; done_delay = 2;
        push(1, 8'h71, 0); drive();
        wait_tx(1, 20);
        chk("t6_lock_before", 32'(lock_active), 1);
        chk("t6_busy_before", 32'(busy), 1);
        push(0, 8'h70, 1); push(2, 8'h72, 1); drive();
        rst = 1'b1;
        #1;
        chk("t6_tx_do", 32'(tx_do), 0);
        chk("t6_ready", 32'(req_ready), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_lock", 32'(lock_active), 0);
        repeat (2) step();
        rst = 1'b0;
        clear_mon();
        wait_idle(100);
        chk_tx("t6", 0, 0, 8'h70); chk_tx("t6", 1, 2, 8'h72);

        // random traffic, random tx_done latency
        rand_mode = 1; rand_done = 1;
        repeat (3000) step();
        rand_mode = 0;
        wait_idle(1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
